// File: rtl/eq_cmp_sched_pkg.sv
// Shared types and constants for the eq_cmp_sched comparator scheduler.
package eq_cmp_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    typedef logic id_t;

    localparam int MATCH_CNT_W = 8;

endpackage

// File: rtl/eq_cmp_sched_rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the loser whenever a grant is accepted.
module rr_arb2
    import eq_cmp_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       any_o,
    output id_t        win_o
);

    id_t prio_q;
    id_t prio_d;

    always_comb begin
        any_o = |req_i;
        if (req_i[0] && req_i[1]) begin
            win_o = prio_q;
        end else if (req_i[1]) begin
            win_o = 1'b1;
        end else begin
            win_o = 1'b0;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (accept_i && any_o) begin
            prio_d = ~win_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/eq_cmp_sched.sv
// Round-robin scheduler sharing one external equality comparator between two requesters.
// Optional saturating match counter enabled by EQ_CMP_SCHED_MATCH_CNT_EN.
module eq_cmp_sched
    import eq_cmp_sched_pkg::*;
#(
    parameter int W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_i,
    input  logic [W-1:0]           a0_i,
    input  logic [W-1:0]           b0_i,
    output logic                   gnt0_o,
    input  logic                   req1_i,
    input  logic [W-1:0]           a1_i,
    input  logic [W-1:0]           b1_i,
    output logic                   gnt1_o,
    output logic [W-1:0]           cmp_in_o,
    output logic                   cmp_push1_o,
    output logic                   cmp_push2_o,
    input  logic                   cmp_eq_i,
    output logic                   rsp_valid_o,
    output logic                   rsp_id_o,
    output logic                   rsp_eq_o,
    input  logic                   rsp_ready_i,
`ifdef EQ_CMP_SCHED_MATCH_CNT_EN
    output logic [MATCH_CNT_W-1:0] match_cnt_o,
`endif
    output logic                   busy_o
);

    state_e         state_q, state_d;
    id_t            id_q, id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           eq_q, eq_d;

    logic           arb_any;
    id_t            arb_win;
    logic           accept;

    assign accept = (state_q == ST_IDLE) && arb_any;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_i, req0_i}),
        .accept_i (accept),
        .any_o    (arb_any),
        .win_o    (arb_win)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d = ST_LOAD_A;
                    id_d    = arb_win;
                    a_d     = arb_win ? a1_i : a0_i;
                    b_d     = arb_win ? b1_i : b0_i;
                end
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_LOAD_B: state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                eq_d    = cmp_eq_i;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
        end
    end

    // Moore outputs: everything decodes from registered state and latched operands.
    always_comb begin
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        cmp_in_o    = a_q;
        cmp_push1_o = 1'b0;
        cmp_push2_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_id_o    = id_q;
        rsp_eq_o    = eq_q;
        busy_o      = (state_q != ST_IDLE);
        case (state_q)
            ST_LOAD_A: begin
                cmp_push1_o = 1'b1;
                gnt0_o      = (id_q == 1'b0);
                gnt1_o      = (id_q == 1'b1);
            end
            ST_LOAD_B: begin
                cmp_in_o    = b_q;
                cmp_push2_o = 1'b1;
            end
            ST_RESP:   rsp_valid_o = 1'b1;
            default:   ;
        endcase
    end

`ifdef EQ_CMP_SCHED_MATCH_CNT_EN
    logic [MATCH_CNT_W-1:0] match_cnt_q, match_cnt_d;

    function automatic logic [MATCH_CNT_W-1:0] sat_inc(input logic [MATCH_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    always_comb begin
        match_cnt_d = match_cnt_q;
        if ((state_q == ST_RESP) && rsp_ready_i && eq_q) begin
            match_cnt_d = sat_inc(match_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt_q <= '0;
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign match_cnt_o = match_cnt_q;
`endif

endmodule

// File: tb/tb_eq_cmp_sched.sv
// Directed self-checking bench for eq_cmp_sched with a behavioural external comparator.
module tb_eq_cmp_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] a0, b0, a1, b1;
    logic       gnt0, gnt1;
    logic [3:0] cmp_in;
    logic       cmp_push1, cmp_push2, cmp_eq;
    logic       rsp_valid, rsp_id, rsp_eq, rsp_ready;
    logic       busy;
`ifdef EQ_CMP_SCHED_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    eq_cmp_sched #(.W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_i      (req0),
        .a0_i        (a0),
        .b0_i        (b0),
        .gnt0_o      (gnt0),
        .req1_i      (req1),
        .a1_i        (a1),
        .b1_i        (b1),
        .gnt1_o      (gnt1),
        .cmp_in_o    (cmp_in),
        .cmp_push1_o (cmp_push1),
        .cmp_push2_o (cmp_push2),
        .cmp_eq_i    (cmp_eq),
        .rsp_valid_o (rsp_valid),
        .rsp_id_o    (rsp_id),
        .rsp_eq_o    (rsp_eq),
        .rsp_ready_i (rsp_ready),
`ifdef EQ_CMP_SCHED_MATCH_CNT_EN
        .match_cnt_o (match_cnt),
`endif
        .busy_o      (busy)
    );

    // External comparator: two unreset operand registers and a combinational compare.
    logic [3:0] cr1 = 4'h0;
    logic [3:0] cr2 = 4'h0;
    always @(posedge clk) begin
        if (cmp_push1) cr1 <= cmp_in;
        if (cmp_push2) cr2 <= cmp_in;
    end
    assign cmp_eq = (cr1 == cr2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input logic id, input logic [3:0] a, input logic [3:0] b,
                          output logic got_id, output logic got_eq, output bit ok);
        ok     = 1'b0;
        got_id = 1'b0;
        got_eq = 1'b0;
        if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; a0 = a; b0 = b; end
        for (int i = 0; i < 10; i++) begin
            step();
            if (gnt0 || gnt1) begin ok = 1'b1; break; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (rsp_valid) begin
                    got_id = rsp_id;
                    got_eq = rsp_eq;
                    ok     = 1'b1;
                    break;
                end
            end
            if (ok) step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; rsp_ready = 1'b1;
        step();
        step();
        n_chk++; if ({gnt0, gnt1, cmp_push1, cmp_push2} !== 4'b0) $display("FAIL rst_strobes: got %b want 0000", {gnt0, gnt1, cmp_push1, cmp_push2}); else n_pass++;
        n_chk++; if (cmp_in !== 4'h0) $display("FAIL rst_cmp_in: got %h want 0", cmp_in); else n_pass++;
        n_chk++; if ({rsp_valid, rsp_id, rsp_eq, busy} !== 4'b0) $display("FAIL rst_rsp_busy: got %b want 0000", {rsp_valid, rsp_id, rsp_eq, busy}); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        req0 = 1'b1; a0 = 4'hA; b0 = 4'hA; rsp_ready = 1'b1;
        step();
        n_chk++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL single_gnt: got %b want 10", {gnt0, gnt1}); else n_pass++;
        n_chk++; if ({cmp_push1, cmp_push2} !== 2'b10) $display("FAIL single_push_c1: got %b want 10", {cmp_push1, cmp_push2}); else n_pass++;
        n_chk++; if (cmp_in !== 4'hA) $display("FAIL single_in_a: got %h want a", cmp_in); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy: got %b want 1", busy); else n_pass++;
        req0 = 1'b0;
        step();
        n_chk++; if ({gnt0, cmp_push1, cmp_push2} !== 3'b001) $display("FAIL single_push_c2: got %b want 001", {gnt0, cmp_push1, cmp_push2}); else n_pass++;
        step();
        n_chk++; if ({cmp_push1, cmp_push2, rsp_valid} !== 3'b000) $display("FAIL single_sample: got %b want 000", {cmp_push1, cmp_push2, rsp_valid}); else n_pass++;
        step();
        n_chk++; if ({rsp_valid, rsp_id, rsp_eq} !== 3'b101) $display("FAIL single_rsp: got %b want 101", {rsp_valid, rsp_id, rsp_eq}); else n_pass++;
        step();
        n_chk++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_idle: got %b want 00", {rsp_valid, busy}); else n_pass++;
    endtask

    task automatic test_mismatch();
        logic gid, geq;
        bit   ok;
        do_txn(1'b1, 4'h3, 4'h7, gid, geq, ok);
        n_chk++; if (!ok) $display("FAIL mismatch_timeout: got timeout want response"); else n_pass++;
        n_chk++; if ({gid, geq} !== 2'b10) $display("FAIL mismatch_rsp: got id/eq %b want 10", {gid, geq}); else n_pass++;
    endtask

    task automatic test_contention();
        logic gids [8];
        logic rids [8];
        logic reqs [8];
        int   ng = 0;
        int   nr = 0;
        int   both = 0;
        rst_n = 1'b0;
        req0 = 1'b1; a0 = 4'h5; b0 = 4'h5;
        req1 = 1'b1; a1 = 4'h2; b1 = 4'h9;
        rsp_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (gnt0 && gnt1) both++;
            if ((gnt0 || gnt1) && ng < 8) begin gids[ng] = gnt1; ng++; end
            if (rsp_valid && nr < 8) begin rids[nr] = rsp_id; reqs[nr] = rsp_eq; nr++; end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        n_chk++; if (both != 0) $display("FAIL cont_dual_gnt: got %0d want 0", both); else n_pass++;
        n_chk++; if (ng != 4) $display("FAIL cont_ngrants: got %0d want 4", ng); else n_pass++;
        n_chk++; if (nr != 4) $display("FAIL cont_nrsp: got %0d want 4", nr); else n_pass++;
        for (int i = 0; i < 4 && i < ng && i < nr; i++) begin
            n_chk++; if (gids[i] !== 1'(i % 2)) $display("FAIL cont_order[%0d]: got %b want %0d", i, gids[i], i % 2); else n_pass++;
            n_chk++; if (rids[i] !== gids[i]) $display("FAIL cont_rsp_id[%0d]: got %b want %b", i, rids[i], gids[i]); else n_pass++;
            n_chk++; if (reqs[i] !== (rids[i] == 1'b0)) $display("FAIL cont_rsp_eq[%0d]: got %b want %b", i, reqs[i], rids[i] == 1'b0); else n_pass++;
        end
        step();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req0 = 1'b1; a0 = 4'h6; b0 = 4'h6;
        step();
        req0 = 1'b0;
        step();
        step();
        step();
        req1 = 1'b1; a1 = 4'h1; b1 = 4'h1;
        for (int i = 0; i < 6; i++) begin
            n_chk++; if ({rsp_valid, rsp_id, rsp_eq} !== 3'b101) $display("FAIL bp_rsp[%0d]: got %b want 101", i, {rsp_valid, rsp_id, rsp_eq}); else n_pass++;
            n_chk++; if ({cmp_push1, cmp_push2, gnt1} !== 3'b000) $display("FAIL bp_quiet[%0d]: got %b want 000", i, {cmp_push1, cmp_push2, gnt1}); else n_pass++;
            n_chk++; if (busy !== 1'b1) $display("FAIL bp_busy[%0d]: got %b want 1", i, busy); else n_pass++;
            step();
        end
        rsp_ready = 1'b1;
        step();
        n_chk++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL bp_release: got %b want 00", {rsp_valid, busy}); else n_pass++;
        step();
        n_chk++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL bp_next_gnt: got %b want 01", {gnt0, gnt1}); else n_pass++;
        req1 = 1'b0;
        step();
        step();
        step();
        n_chk++; if ({rsp_valid, rsp_id, rsp_eq} !== 3'b111) $display("FAIL bp_next_rsp: got %b want 111", {rsp_valid, rsp_id, rsp_eq}); else n_pass++;
        step();
    endtask

    task automatic test_reset_mid();
        logic gid, geq;
        bit   ok;
        int   stray = 0;
        rsp_ready = 1'b1;
        req0 = 1'b1; a0 = 4'h9; b0 = 4'h4;
        step();
        req0 = 1'b0;
        step();
        n_chk++; if (cmp_push2 !== 1'b1) $display("FAIL rmid_in_load_b: got %b want 1", cmp_push2); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if ({gnt0, gnt1, cmp_push1, cmp_push2, busy} !== 5'b0) $display("FAIL rmid_ctrl: got %b want 00000", {gnt0, gnt1, cmp_push1, cmp_push2, busy}); else n_pass++;
        n_chk++; if ({cmp_in, rsp_valid, rsp_id, rsp_eq} !== 7'b0) $display("FAIL rmid_data: got %b want 0000000", {cmp_in, rsp_valid, rsp_id, rsp_eq}); else n_pass++;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid || busy) stray++;
        end
        n_chk++; if (stray != 0) $display("FAIL rmid_stray: got %0d active cycles want 0", stray); else n_pass++;
        do_txn(1'b1, 4'h4, 4'h4, gid, geq, ok);
        n_chk++; if (!ok || {gid, geq} !== 2'b11) $display("FAIL rmid_next: got ok=%0d id/eq %b want ok=1 11", ok, {gid, geq}); else n_pass++;
    endtask

`ifdef EQ_CMP_SCHED_MATCH_CNT_EN
    task automatic test_match_cnt();
        logic gid, geq;
        bit   ok;
        int   tmo = 0;
        rsp_ready = 1'b1;
        apply_reset();
        n_chk++; if (match_cnt !== 8'd0) $display("FAIL mc_reset: got %0d want 0", match_cnt); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            do_txn(1'(i % 2), 4'hC, 4'hC, gid, geq, ok);
            if (!ok) tmo++;
        end
        n_chk++; if (match_cnt !== 8'd3) $display("FAIL mc_three: got %0d want 3", match_cnt); else n_pass++;
        do_txn(1'b0, 4'h1, 4'h2, gid, geq, ok);
        if (!ok) tmo++;
        n_chk++; if (match_cnt !== 8'd3) $display("FAIL mc_miss_hold: got %0d want 3", match_cnt); else n_pass++;
        for (int i = 0; i < 297; i++) begin
            do_txn(1'(i % 2), 4'(i), 4'(i), gid, geq, ok);
            if (!ok) tmo++;
        end
        n_chk++; if (match_cnt !== 8'd255) $display("FAIL mc_sat: got %0d want 255", match_cnt); else n_pass++;
        do_txn(1'b1, 4'h7, 4'h8, gid, geq, ok);
        if (!ok) tmo++;
        n_chk++; if (match_cnt !== 8'd255) $display("FAIL mc_sat_miss: got %0d want 255", match_cnt); else n_pass++;
        n_chk++; if (tmo != 0) $display("FAIL mc_timeouts: got %0d want 0", tmo); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_mismatch();
        test_contention();
        test_backpressure();
        test_reset_mid();
`ifdef EQ_CMP_SCHED_MATCH_CNT_EN
        test_match_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1);
    end

endmodule
